// File: rtl/spi_eeprom_slave.sv
// spi_eeprom_slave
//   SPI mode-0 responder emulating a small 25AA-style serial EEPROM
//   (WREN/WRDI/RDSR/WRITE/READ). The SPI lines are oversampled with clk_50M;
//   SCK is never used as a clock.
//
// Ports
//   clk_50M    system clock (the only clock)
//   reset      synchronous, active-high reset
//   spi_csn    chip select, active low
//   spi_sck    SPI clock, CPOL=0 / CPHA=0
//   spi_si     MOSI
//   spi_so     MISO, driven 0 whenever not shifting out read/status data
//   wel        write-enable latch (status bit 1)
//   wip        write in progress (status bit 0)
//   wr_strobe  one-cycle pulse when a byte is committed to the array
//   wr_addr    address of the last commit
//   wr_data    data of the last commit
//
// Configuration macro
//   SPI_EEPROM_SLAVE_WIP_TIMER_EN : when defined, every commit holds wip high
//   for WRITE_CYCLES clocks; only RDSR is honoured meanwhile. When undefined,
//   wip is tied low and WRITE_CYCLES is unused.
module spi_eeprom_slave #(
    parameter int ADDR_W       = 4,
    parameter int WRITE_CYCLES = 250
) (
    input  logic              clk_50M,
    input  logic              reset,
    input  logic              spi_csn,
    input  logic              spi_sck,
    input  logic              spi_si,
    output logic              spi_so,
    output logic              wel,
    output logic              wip,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, STAT, IGNORE} state_t;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;

    state_t state, state_nxt;

    logic [1:0]        csn_sync, sck_sync, si_sync;
    logic              csn_q, sck_q;
    logic              csn_fall, csn_rise, sck_rise, sck_fall;
    logic [2:0]        bit_cnt;
    logic [1:0]        byte_cnt;
    logic [6:0]        shift_in;
    logic [7:0]        byte_in;
    logic              byte_done;
    logic [ADDR_W-1:0] addr, addr_inc, addr_in;
    logic [7:0]        wbuf;
    logic              overrun;
    logic              is_read;
    logic [7:0]        tx_shift;
    logic [7:0]        status;
    logic              commit;
    logic              cmd_ok;

    logic [7:0] mem [2**ADDR_W];

    // Synchronizers keep sampling through reset so that a frame already in
    // progress when reset drops is not mistaken for a fresh CSN fall.
    always_ff @(posedge clk_50M) begin
        csn_sync <= {csn_sync[0], spi_csn};
        sck_sync <= {sck_sync[0], spi_sck};
        si_sync  <= {si_sync[0], spi_si};
        csn_q    <= csn_sync[1];
        sck_q    <= sck_sync[1];
    end

    assign csn_fall = csn_q & ~csn_sync[1];
    assign csn_rise = ~csn_q & csn_sync[1];
    // SCK edges only count while synced CSN is low, so a CSN rise landing
    // with an SCK rise drops the partial bit.
    assign sck_rise = ~sck_q & sck_sync[1] & ~csn_sync[1];
    assign sck_fall = sck_q & ~sck_sync[1] & ~csn_sync[1];

    assign byte_in   = {shift_in, si_sync[1]};
    assign byte_done = sck_rise && (state != IDLE) && (bit_cnt == 3'd7);
    assign addr_inc  = addr + ADDR_W'(1);
    assign addr_in   = byte_in[ADDR_W-1:0];
    assign status    = {6'b0, wel, wip};
    assign cmd_ok    = !wip || (byte_in == OP_RDSR);

    // Exactly three whole bytes and nothing after them.
    assign commit = csn_rise && (state == WDATA) && (byte_cnt == 2'd3) &&
                    (bit_cnt == 3'd0) && !overrun;

    always_ff @(posedge clk_50M) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (csn_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (csn_fall) state_nxt = CMD;
                CMD: if (byte_done) begin
                    if (!cmd_ok) begin
                        state_nxt = IGNORE;
                    end else begin
                        case (byte_in)
                            OP_RDSR:  state_nxt = STAT;
                            OP_READ:  state_nxt = ADDR;
                            OP_WRITE: state_nxt = wel ? ADDR : IGNORE;
                            default:  state_nxt = IGNORE;
                        endcase
                    end
                end
                ADDR: if (byte_done) state_nxt = is_read ? RDATA : WDATA;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shift_in  <= '0;
            addr      <= '0;
            wbuf      <= '0;
            overrun   <= 1'b0;
            is_read   <= 1'b0;
            tx_shift  <= '0;
            spi_so    <= 1'b0;
            wel       <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_strobe <= commit;
            if (commit) begin
                wr_addr <= addr;
                wr_data <= wbuf;
                wel     <= 1'b0;
            end

            if (state == IDLE) begin
                if (csn_fall) begin
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                    shift_in <= '0;
                    overrun  <= 1'b0;
                end
            end else if (sck_rise) begin
                shift_in <= byte_in[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7 && byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
                if (state == WDATA && byte_cnt == 2'd3) overrun <= 1'b1;
            end

            if (byte_done) begin
                case (state)
                    CMD: if (cmd_ok) begin
                        case (byte_in)
                            OP_WREN:  wel <= 1'b1;
                            OP_WRDI:  wel <= 1'b0;
                            OP_READ:  is_read <= 1'b1;
                            OP_WRITE: is_read <= 1'b0;
                            OP_RDSR:  tx_shift <= status;
                            default:  ;
                        endcase
                    end
                    ADDR: begin
                        addr <= addr_in;
                        if (is_read) tx_shift <= mem[addr_in];
                    end
                    // byte_cnt is still 2 on the first data byte
                    WDATA: if (byte_cnt == 2'd2) wbuf <= byte_in;
                    RDATA: begin
                        addr     <= addr_inc;
                        tx_shift <= mem[addr_inc];
                    end
                    STAT: tx_shift <= status;
                    default: ;
                endcase
            end

            // MISO is registered and advances on SCK fall so the MSB of a byte
            // loaded at a byte boundary goes out on the following fall.
            if (csn_rise) begin
                spi_so <= 1'b0;
            end else if (state == RDATA || state == STAT) begin
                if (sck_fall) begin
                    spi_so   <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end else begin
                spi_so <= 1'b0;
            end
        end
    end

    // Array is not reset.
    always_ff @(posedge clk_50M) begin
        if (commit) mem[addr] <= wbuf;
    end

`ifdef SPI_EEPROM_SLAVE_WIP_TIMER_EN
    localparam int CNT_W = $clog2(WRITE_CYCLES + 1);
    logic [CNT_W-1:0] wip_cnt;

    // wip rises the cycle after wr_strobe and stays up WRITE_CYCLES cycles.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            wip     <= 1'b0;
            wip_cnt <= '0;
        end else if (wr_strobe) begin
            wip     <= 1'b1;
            wip_cnt <= CNT_W'(WRITE_CYCLES - 1);
        end else if (wip) begin
            if (wip_cnt == '0) wip <= 1'b0;
            else               wip_cnt <= wip_cnt - 1'b1;
        end
    end
`else
    logic unused_write_cycles;
    assign unused_write_cycles = (WRITE_CYCLES != 0);
    assign wip = 1'b0;
`endif

endmodule
